// File: rtl/circle_pixel_writer.sv
// ---------------------------------------------------------------------------
// circle_pixel_writer
//
// Purpose:
//   Receiving end of the circle drawer's 8-point output. One transfer delivers
//   a bundle of eight octant points plus one colour. Points that fall outside
//   the visible area, or that repeat an earlier point of the same bundle, are
//   dropped. The remaining points go out one at a time, in index order, as
//   single-pixel frame-buffer writes: a linear address plus a 12-bit colour.
//
// Ports:
//   clk, rst                 system clock; asynchronous active-high reset
//   draw_x_0..7, draw_y_0..7 point coordinates (10 bits each). A negative
//                            coordinate arrives wrapped, so it reads as a
//                            large value and is treated as off-screen.
//   color                    RGB444 colour shared by the whole bundle
//   in_rts / in_rtr          bundle handshake; a transfer happens when both
//                            are high on a rising edge
//   out_rts / out_rtr        pixel write handshake toward the arbiter
//   out_addr                 linear address y*H_RES + x
//   out_color                colour of the pixel write
//   busy                     high while a bundle is held (any state but IDLE)
// ---------------------------------------------------------------------------
module circle_pixel_writer #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        draw_x_0,
  input  logic [9:0]        draw_x_1,
  input  logic [9:0]        draw_x_2,
  input  logic [9:0]        draw_x_3,
  input  logic [9:0]        draw_x_4,
  input  logic [9:0]        draw_x_5,
  input  logic [9:0]        draw_x_6,
  input  logic [9:0]        draw_x_7,
  input  logic [9:0]        draw_y_0,
  input  logic [9:0]        draw_y_1,
  input  logic [9:0]        draw_y_2,
  input  logic [9:0]        draw_y_3,
  input  logic [9:0]        draw_y_4,
  input  logic [9:0]        draw_y_5,
  input  logic [9:0]        draw_y_6,
  input  logic [9:0]        draw_y_7,
  input  logic [11:0]       color,
  input  logic              in_rts,
  output logic              in_rtr,
  output logic              out_rts,
  input  logic              out_rtr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [11:0]       out_color,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd7;

  // Registered state
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [9:0]          x_q [8];
  logic [9:0]          x_d [8];
  logic [9:0]          y_q [8];
  logic [9:0]          y_d [8];
  logic [11:0]         color_q, color_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [11:0]         out_color_q, out_color_d;

  // Incoming coordinates gathered into arrays so they can be loaded in a loop
  logic [9:0]          in_x [8];
  logic [9:0]          in_y [8];

  // Point currently under evaluation and its qualification
  logic [9:0]          cur_x;
  logic [9:0]          cur_y;
  logic                on_screen;
  logic                is_dup;
  logic                point_ok;
  logic [ADDR_W-1:0]   cur_addr;

  logic                in_xfc;
  logic                out_xfc;

  always_comb begin
    in_x[0] = draw_x_0;
    in_x[1] = draw_x_1;
    in_x[2] = draw_x_2;
    in_x[3] = draw_x_3;
    in_x[4] = draw_x_4;
    in_x[5] = draw_x_5;
    in_x[6] = draw_x_6;
    in_x[7] = draw_x_7;
    in_y[0] = draw_y_0;
    in_y[1] = draw_y_1;
    in_y[2] = draw_y_2;
    in_y[3] = draw_y_3;
    in_y[4] = draw_y_4;
    in_y[5] = draw_y_5;
    in_y[6] = draw_y_6;
    in_y[7] = draw_y_7;
  end

  // Handshake decodes. in_rtr is masked by rst so nothing can be accepted
  // while the block is held in reset.
  assign in_rtr  = (state_q == ST_IDLE) & ~rst;
  assign out_rts = (state_q == ST_SEND);
  assign busy    = (state_q != ST_IDLE);
  assign in_xfc  = in_rts & in_rtr;
  assign out_xfc = out_rts & out_rtr;

  assign out_addr  = addr_q;
  assign out_color = out_color_q;

  // Qualify the point at idx. The duplicate search compares raw coordinates
  // against every lower index, so a repeat is dropped even when the earlier
  // copy was itself off-screen.
  always_comb begin
    cur_x     = x_q[idx_q];
    cur_y     = y_q[idx_q];
    on_screen = (32'(cur_x) < H_RES) && (32'(cur_y) < V_RES);
    is_dup    = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if ((3'(j) < idx_q) && (x_q[j] == cur_x) && (y_q[j] == cur_y)) begin
        is_dup = 1'b1;
      end
    end
    point_ok = on_screen && !is_dup;
    cur_addr = ADDR_W'(cur_y) * ADDR_W'(H_RES) + ADDR_W'(cur_x);
  end

  // Next-state logic: IDLE captures a bundle, SCAN spends one cycle on each
  // index, SEND holds a qualified pixel until the arbiter takes it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    color_d     = color_q;
    addr_d      = addr_q;
    out_color_d = out_color_q;
    for (int i = 0; i < 8; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_xfc) begin
          for (int i = 0; i < 8; i++) begin
            x_d[i] = in_x[i];
            y_d[i] = in_y[i];
          end
          color_d = color;
          idx_d   = 3'd0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (point_ok) begin
          addr_d      = cur_addr;
          out_color_d = color_q;
          state_d     = ST_SEND;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      ST_SEND: begin
        if (out_xfc) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SCAN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any bundle in flight; because out_rts is
  // a decode of state it drops together with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      color_q     <= 12'd0;
      addr_q      <= '0;
      out_color_q <= 12'd0;
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      color_q     <= color_d;
      addr_q      <= addr_d;
      out_color_q <= out_color_d;
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

endmodule

// File: doc/circle_pixel_writer.md
# circle_pixel_writer

Consumer end of the circle drawer's 8-point output handshake. Accepts one bundle of eight octant points plus colour per transfer. Drops points that are off-screen or duplicated within the bundle. Serializes the survivors into single-pixel frame-buffer writes (linear address + 12-bit colour) over an rts/rtr handshake toward the frame-buffer arbiter.

## Interface
- H_RES, 640, visible width; x valid when x < H_RES
- V_RES, 480, visible height; y valid when y < V_RES
- ADDR_W, 19, frame-buffer address width; must hold H_RES*V_RES-1
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- draw_x_0..draw_x_7  input  10 each  point x coordinates; wrapped (underflowed) values are off-screen
- draw_y_0..draw_y_7  input  10 each  point y coordinates
- color  input  12  RGB444 colour for the bundle
- in_rts  input  1  upstream bundle valid
- in_rtr  output  1  ready for a bundle
- out_rts  output  1  pixel write valid
- out_rtr  input  1  arbiter ready
- out_addr  output  ADDR_W  linear address y*H_RES + x
- out_color  output  12  pixel colour
- busy  output  1  high whenever state != IDLE

## Operation
- in_xfc = in_rts & in_rtr; out_xfc = out_rts & out_rtr.
- States: IDLE, SCAN, SEND.
- IDLE:
  - in_rtr = 1.
  - On in_xfc: register all 16 coordinates and color, idx <= 0, go to SCAN.
- SCAN: evaluate point idx. It is valid when both hold:
  - x_idx < H_RES and y_idx < V_RES.
  - No lower index j < idx has (x_j, y_j) == (x_idx, y_idx). Duplicate test uses raw coordinates, including off-screen ones.
- SCAN, point valid: out_addr <= y_idx*H_RES + x_idx, computed at ADDR_W bits with no truncation. out_color <= held colour. Go to SEND.
- SCAN, point invalid: if idx == 7 go to IDLE, else idx <= idx+1 and stay in SCAN.
- SEND:
  - out_rts = 1; out_addr and out_color are stable until out_xfc.
  - On out_xfc: if idx == 7 go to IDLE, else idx <= idx+1 and go to SCAN.
- in_rtr and out_rts are decodes of state.
- Inputs are ignored outside IDLE. The held bundle is never overwritten mid-serialization.
- Emission order is strictly ascending index.

## Timing
- Reset state while rst is high: state=IDLE, idx=0, out_addr=0, out_color=0.
- Output values during reset: out_rts=0, busy=0, in_rtr=0 (in_rtr is gated off while rst is high).
- Reset mid-SEND aborts the bundle. No further writes are issued, and out_rts falls asynchronously with rst.
- Each point costs 1 SCAN cycle. A valid point adds at least 1 SEND cycle, plus one extra cycle per cycle out_rtr is low.
- Full bundle, 8 distinct on-screen points, out_rtr held high:
  - Acceptance edge at cycle 0.
  - SEND in cycles 2, 4, ..., 16.
  - IDLE again, with in_rtr=1, in cycle 17.
- All 8 points invalid: 8 SCAN cycles, IDLE in cycle 9.
- A new in_xfc is possible in the first IDLE cycle. There are no bubbles beyond those listed above.
- out_rtr may toggle freely. A write completes only on a cycle with out_rts & out_rtr.

## Test plan
- r=0 bundle, all 8 points = (100,100), colour 0xF00, out_rtr=1 -> exactly one write, addr 64100, colour 0xF00; in_rtr high again 10 cycles after acceptance.
- 8 distinct points (10,20),(20,10),(0,10),(-10→1014,20),…, out_rtr=1 -> only on-screen points written, in index order; (1014,20) dropped; addr(10,20)=12810.
- Corner (639,479) and (640,479) in one bundle -> addr 307199 written; (640,479) dropped.
- Backpressure: 8 distinct valid points, out_rtr low for 5 cycles during the 3rd write -> out_addr/out_color held constant; 8 writes total; IDLE 5 cycles later than the unstalled case (cycle 22).
- in_rts held high throughout -> second bundle accepted only in the IDLE cycle after the first completes; first bundle's writes unaffected.
- rst pulsed during the 4th SEND -> out_rts=0 immediately; no further writes; after release in_rtr=1 and a fresh bundle serializes correctly.
